// File: rtl/axis_vc_queue_if.sv
// Handshake bundle for axis_vc_queue: one VC-tagged input beat stream and
// the registered output beat stream.
interface axis_vc_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4,
    parameter int NUM_VC     = 4
);
    localparam int VCW = $clog2(NUM_VC);

    logic [VCW-1:0]        in_vc_i;
    logic                  in_tvalid_i;
    logic [NUM_VC-1:0]     in_tready_o;
    logic [DATA_WIDTH-1:0] in_tdata_i;
    logic [ID_WIDTH-1:0]   in_tid_i;
    logic [DEST_WIDTH-1:0] in_tdest_i;
    logic [USER_WIDTH-1:0] in_tuser_i;
    logic                  in_tlast_i;

    logic                  out_tvalid_o;
    logic                  out_tready_i;
    logic [DATA_WIDTH-1:0] out_tdata_o;
    logic [ID_WIDTH-1:0]   out_tid_o;
    logic [DEST_WIDTH-1:0] out_tdest_o;
    logic [USER_WIDTH-1:0] out_tuser_o;
    logic                  out_tlast_o;
    logic [VCW-1:0]        out_vc_o;

    // Upstream source / downstream sink view
    modport master (
        output in_vc_i, in_tvalid_i, in_tdata_i, in_tid_i, in_tdest_i, in_tuser_i, in_tlast_i,
        output out_tready_i,
        input  in_tready_o,
        input  out_tvalid_o, out_tdata_o, out_tid_o, out_tdest_o, out_tuser_o, out_tlast_o, out_vc_o
    );

    // Queue view
    modport slave (
        input  in_vc_i, in_tvalid_i, in_tdata_i, in_tid_i, in_tdest_i, in_tuser_i, in_tlast_i,
        input  out_tready_i,
        output in_tready_o,
        output out_tvalid_o, out_tdata_o, out_tid_o, out_tdest_o, out_tuser_o, out_tlast_o, out_vc_o
    );
endinterface

// File: rtl/axis_vc_queue.sv
// Multi-VC AXI-Stream queue: per-VC circular FIFOs in one shared storage
// array, drained by a round-robin arbiter into a registered output stage,
// optionally holding the grant for a whole packet.
module axis_vc_queue #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 4,
    parameter int USER_WIDTH  = 4,
    parameter int NUM_VC      = 4,
    parameter int DEPTH       = 8,
    parameter int PACKET_LOCK = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    axis_vc_queue_if.slave                       bus,
    output logic [NUM_VC*$clog2(DEPTH+1)-1:0]    occupancy_o
);
    localparam int VCW  = $clog2(NUM_VC);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int AW   = $clog2(NUM_VC*DEPTH);
    localparam int PW   = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    typedef logic [PW-1:0] beat_t;

    // Shared storage; VC v owns addresses v*DEPTH .. v*DEPTH+DEPTH-1
    beat_t mem [NUM_VC*DEPTH];

    logic [PTRW-1:0] wptr_reg   [NUM_VC];
    logic [PTRW-1:0] rptr_reg   [NUM_VC];
    logic [CW-1:0]   count_reg  [NUM_VC];
    logic [CW-1:0]   count_next [NUM_VC];
    logic            ready_reg  [NUM_VC];

    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] pop_vec;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] ready_vec;

    logic            push;
    logic            load;
    logic            pop;
    logic            grant_found;
    logic [VCW-1:0]  grant_vc;
    logic [VCW-1:0]  cand;
    logic            locked;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    beat_t           in_beat;

    logic            out_valid_reg;
    beat_t           out_beat_reg;
    logic [VCW-1:0]  out_vc_reg;
    logic [VCW-1:0]  rr_reg;
    logic            popped_reg;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        assign push_vec[gi]  = bus.in_tvalid_i && (bus.in_vc_i == VCW'(gi)) && ready_reg[gi];
        assign pop_vec[gi]   = pop && (grant_vc == VCW'(gi));
        assign eligible[gi]  = !locked || (out_vc_reg == VCW'(gi));
        assign ready_vec[gi] = ready_reg[gi];
        assign count_next[gi] = count_reg[gi] + CW'(push_vec[gi]) - CW'(pop_vec[gi]);
        assign occupancy_o[gi*CW +: CW] = count_reg[gi];

        // Per-VC pointers, beat count and registered ready (count < DEPTH)
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_reg[gi]  <= '0;
                rptr_reg[gi]  <= '0;
                count_reg[gi] <= '0;
                ready_reg[gi] <= 1'b1;
            end else begin
                if (push_vec[gi]) wptr_reg[gi] <= wptr_reg[gi] + 1'b1;
                if (pop_vec[gi])  rptr_reg[gi] <= rptr_reg[gi] + 1'b1;
                count_reg[gi] <= count_next[gi];
                ready_reg[gi] <= (count_next[gi] < CW'(DEPTH));
            end
        end
    end

    assign push    = |push_vec;
    assign in_beat = {bus.in_tdata_i, bus.in_tid_i, bus.in_tdest_i, bus.in_tuser_i, bus.in_tlast_i};
    assign wr_addr = AW'(bus.in_vc_i) * AW'(DEPTH) + AW'(wptr_reg[bus.in_vc_i]);
    assign rd_addr = AW'(grant_vc) * AW'(DEPTH) + AW'(rptr_reg[grant_vc]);

    // The last popped beat (still in the output register) tells whether a
    // packet is open on out_vc_reg; popped_reg masks the cleared reset value.
    assign locked = (PACKET_LOCK != 0) && popped_reg && !out_beat_reg[0];
    assign load   = !out_valid_reg || bus.out_tready_i;
    assign pop    = load && grant_found;

    // Round-robin search for the first eligible non-empty VC from rr_reg
    always_comb begin
        grant_found = 1'b0;
        grant_vc    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand = VCW'((int'(rr_reg) + i) % NUM_VC);
            if (!grant_found && eligible[cand] && (count_reg[cand] != '0)) begin
                grant_found = 1'b1;
                grant_vc    = cand;
            end
        end
    end

    // Storage write port; no reset so the array stays RAM-mappable
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_addr] <= in_beat;
    end

    // Output register: loads a popped beat (registered RAM read) when empty or accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg <= 1'b0;
            out_beat_reg  <= '0;
            out_vc_reg    <= '0;
            rr_reg        <= '0;
            popped_reg    <= 1'b0;
        end else if (load) begin
            out_valid_reg <= grant_found;
            if (grant_found) begin
                out_beat_reg <= mem[rd_addr];
                out_vc_reg   <= grant_vc;
                rr_reg       <= (grant_vc == VCW'(NUM_VC-1)) ? '0 : grant_vc + 1'b1;
                popped_reg   <= 1'b1;
            end
        end
    end

    assign bus.in_tready_o  = ready_vec;
    assign bus.out_tvalid_o = out_valid_reg;
    assign bus.out_vc_o     = out_vc_reg;
    assign {bus.out_tdata_o, bus.out_tid_o, bus.out_tdest_o, bus.out_tuser_o, bus.out_tlast_o} = out_beat_reg;
endmodule

// File: tb/tb_axis_vc_queue.sv
// Bench for axis_vc_queue: two instances (per-beat round-robin and packet
// lock) share one stimulus stream and are checked every cycle against a
// queue-based reference model.
module tb_axis_vc_queue;
    localparam int NUM_VC = 4;
    localparam int DEPTH  = 8;
    localparam int VCW    = $clog2(NUM_VC);
    localparam int CW     = $clog2(DEPTH+1);
    localparam int PW     = 32 + 4 + 4 + 4 + 1;

    typedef logic [PW-1:0] beat_t;

    logic clk_i;
    logic rst_i;

    logic [VCW-1:0] in_vc;
    logic           in_valid;
    beat_t          in_beat;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    axis_vc_queue_if #(.NUM_VC(NUM_VC)) if0 ();
    axis_vc_queue_if #(.NUM_VC(NUM_VC)) if1 ();
    logic [NUM_VC*CW-1:0] occ0;
    logic [NUM_VC*CW-1:0] occ1;

    axis_vc_queue #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .PACKET_LOCK(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if0), .occupancy_o(occ0));
    axis_vc_queue #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .PACKET_LOCK(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(if1), .occupancy_o(occ1));

    assign if0.in_vc_i = in_vc;
    assign if0.in_tvalid_i = in_valid;
    assign {if0.in_tdata_i, if0.in_tid_i, if0.in_tdest_i, if0.in_tuser_i, if0.in_tlast_i} = in_beat;
    assign if0.out_tready_i = out_ready;
    assign if1.in_vc_i = in_vc;
    assign if1.in_tvalid_i = in_valid;
    assign {if1.in_tdata_i, if1.in_tid_i, if1.in_tdest_i, if1.in_tuser_i, if1.in_tlast_i} = in_beat;
    assign if1.out_tready_i = out_ready;

    logic                 o_valid [2];
    beat_t                o_beat  [2];
    logic [VCW-1:0]       o_vc    [2];
    logic [NUM_VC-1:0]    o_ready [2];
    logic [NUM_VC*CW-1:0] o_occ   [2];

    assign o_valid[0] = if0.out_tvalid_o;
    assign o_beat[0]  = {if0.out_tdata_o, if0.out_tid_o, if0.out_tdest_o, if0.out_tuser_o, if0.out_tlast_o};
    assign o_vc[0]    = if0.out_vc_o;
    assign o_ready[0] = if0.in_tready_o;
    assign o_occ[0]   = occ0;
    assign o_valid[1] = if1.out_tvalid_o;
    assign o_beat[1]  = {if1.out_tdata_o, if1.out_tid_o, if1.out_tdest_o, if1.out_tuser_o, if1.out_tlast_o};
    assign o_vc[1]    = if1.out_vc_o;
    assign o_ready[1] = if1.in_tready_o;
    assign o_occ[1]   = occ1;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: one queue per VC, plus the visible output beat
    beat_t mq [2][NUM_VC][$];
    bit    m_valid  [2];
    beat_t m_beat   [2];
    int    m_vc     [2];
    int    m_rr     [2];
    bit    m_lock   [2];
    int    m_lvc    [2];
    bit    m_pushed [2];

    task automatic chk(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d got=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        int    v;
        bit    found;
        beat_t b;
        m_pushed[k] = 1'b0;
        if (rst_i) begin
            for (int i = 0; i < NUM_VC; i++) mq[k][i].delete();
            m_valid[k] = 1'b0; m_beat[k] = '0; m_vc[k] = 0;
            m_rr[k] = 0; m_lock[k] = 1'b0; m_lvc[k] = 0;
            return;
        end
        m_pushed[k] = in_valid && (mq[k][int'(in_vc)].size() < DEPTH);
        if (m_valid[k] && out_ready)
            $display("tx dut%0d vc=%0d data=%h last=%0b", k, m_vc[k], m_beat[k][PW-1 -: 32], m_beat[k][0]);
        if (!m_valid[k] || out_ready) begin
            found = 1'b0;
            v = 0;
            if (m_lock[k]) begin
                if (mq[k][m_lvc[k]].size() > 0) begin found = 1'b1; v = m_lvc[k]; end
            end else begin
                for (int i = 0; i < NUM_VC; i++) begin
                    int c;
                    c = (m_rr[k] + i) % NUM_VC;
                    if (!found && mq[k][c].size() > 0) begin found = 1'b1; v = c; end
                end
            end
            m_valid[k] = found;
            if (found) begin
                b = mq[k][v].pop_front();
                m_beat[k] = b;
                m_vc[k]   = v;
                m_rr[k]   = (v + 1) % NUM_VC;
                m_lock[k] = (k == 1) && !b[0];
                m_lvc[k]  = v;
            end
        end
        if (m_pushed[k]) mq[k][int'(in_vc)].push_back(in_beat);
    endtask

    task automatic compare(input int k);
        logic [NUM_VC*CW-1:0] eo;
        logic [NUM_VC-1:0]    er;
        for (int v = 0; v < NUM_VC; v++) begin
            eo[v*CW +: CW] = CW'(mq[k][v].size());
            er[v] = (mq[k][v].size() < DEPTH);
        end
        chk("out_tvalid", k, 64'(o_valid[k]), 64'(m_valid[k]));
        if (m_valid[k]) begin
            chk("out_beat", k, 64'(o_beat[k]), 64'(m_beat[k]));
            chk("out_vc", k, 64'(o_vc[k]), 64'(m_vc[k]));
        end
        chk("in_tready", k, 64'(o_ready[k]), 64'(er));
        chk("occupancy", k, 64'(o_occ[k]), 64'(eo));
    endtask

    // One clock: check current outputs, advance the model, cross the edge
    task automatic step();
        compare(0);
        compare(1);
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Hold one beat until at least one instance accepts it
    task automatic drive_beat(input int vc, input logic [31:0] data, input logic last);
        int budget;
        in_vc    = VCW'(vc);
        in_beat  = {data, data[3:0], data[7:4], data[11:8], last};
        in_valid = 1'b1;
        budget   = 0;
        do begin
            step();
            budget++;
        end while (!(m_pushed[0] || m_pushed[1]) && budget < 300);
        chk("push_timeout", 0, 64'(budget < 300), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic reset_checks();
        for (int k = 0; k < 2; k++) begin
            chk("rst_tready", k, 64'(o_ready[k]), 64'({NUM_VC{1'b1}}));
            chk("rst_tvalid", k, 64'(o_valid[k]), 64'(0));
            chk("rst_payload", k, 64'(o_beat[k]), 64'(0));
            chk("rst_vc", k, 64'(o_vc[k]), 64'(0));
            chk("rst_occ", k, 64'(o_occ[k]), 64'(0));
        end
    endtask

    initial begin
        rst_i = 1'b1; in_valid = 1'b0; in_vc = '0; in_beat = '0; out_ready = 1'b1;
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        #1;
        step();
        rst_i = 1'b0;
        reset_checks();

        // Single beat latency: push in cycle 0, visible in cycle 2
        drive_beat(2, 32'hA5, 1'b1);
        for (int k = 0; k < 2; k++) chk("lat_occ1", k, 64'(o_occ[k][2*CW +: CW]), 64'(1));
        step();
        for (int k = 0; k < 2; k++) begin
            chk("lat_valid", k, 64'(o_valid[k]), 64'(1));
            chk("lat_data", k, 64'(o_beat[k][PW-1 -: 32]), 64'(32'hA5));
            chk("lat_vc", k, 64'(o_vc[k]), 64'(2));
        end
        step();
        for (int k = 0; k < 2; k++) chk("lat_occ0", k, 64'(o_occ[k][2*CW +: CW]), 64'(0));
        idle(3);

        // Fill VC1 under backpressure (one beat sits in the output register)
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) drive_beat(1, 32'(i), 1'b1);
        for (int k = 0; k < 2; k++) chk("fill_ready", k, 64'(o_ready[k]), 64'(4'b1101));
        in_vc = VCW'(1); in_beat = {32'd9, 4'd9, 4'd0, 4'd0, 1'b1}; in_valid = 1'b1;
        repeat (3) step();
        out_ready = 1'b1;
        drive_beat(1, 32'd9, 1'b1);
        idle(14);

        // Wrap-around through VC0 at full rate
        for (int i = 0; i < 20; i++) drive_beat(0, 32'(100 + i), 1'b1);
        idle(4);

        // Round-robin across preloaded VCs
        out_ready = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < NUM_VC; v++) drive_beat(v, 32'(200 + r*16 + v), 1'b1);
        out_ready = 1'b1;
        idle(12);

        // Packet lock: VC0 tail delayed, VC1 single beat waiting
        drive_beat(0, 32'h300, 1'b0);
        drive_beat(0, 32'h301, 1'b0);
        drive_beat(1, 32'h310, 1'b1);
        idle(4);
        drive_beat(0, 32'h302, 1'b1);
        idle(6);

        // Reset in the middle of a locked packet on VC3
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive_beat(3, 32'(32'h400 + i), 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        reset_checks();
        out_ready = 1'b1;
        drive_beat(0, 32'h500, 1'b1);
        idle(3);

        // Randomized traffic: light then heavy backpressure
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 400; n++) begin
                if (!in_valid || m_pushed[0] || m_pushed[1]) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_vc    = VCW'($urandom_range(0, NUM_VC-1));
                    in_beat  = {$urandom(), 4'($urandom()), 4'($urandom()), 4'($urandom()),
                                ($urandom_range(0, 2) == 0)};
                end
                out_ready = (phase == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
                step();
            end
        end
        out_ready = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
